// File: rtl/mux16_rr_scheduler_if.sv
// Handshake bundle between the round-robin scheduler and its requesters / 16:1 mux.
// Ports: en, req[15:0], mux_w in; sel[3:0], sel_valid, grant[15:0], data_out, data_valid, busy out.
interface mux16_rr_scheduler_if;
    logic        en;
    logic [15:0] req;
    logic        mux_w;
    logic [3:0]  sel;
    logic        sel_valid;
    logic [15:0] grant;
    logic        data_out;
    logic        data_valid;
    logic        busy;

    modport slave (
        input  en,
        input  req,
        input  mux_w,
        output sel,
        output sel_valid,
        output grant,
        output data_out,
        output data_valid,
        output busy
    );

    modport master (
        output en,
        output req,
        output mux_w,
        input  sel,
        input  sel_valid,
        input  grant,
        input  data_out,
        input  data_valid,
        input  busy
    );
endinterface

// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler driving the select of a shared 16:1 bit mux and sampling its output.
// Ports: clk, rst_n (async active-low), bus (slave modport: en/req/mux_w in, sel/grant/data out).
module mux16_rr_scheduler #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux16_rr_scheduler_if.slave   bus
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    logic [1:0]    state;
    logic [3:0]    ptr;
    logic [3:0]    sel_q;
    logic [CW-1:0] cnt;
    logic          dout_q;
    logic          dv_q;

    logic          found;
    logic [3:0]    winner;
    logic [3:0]    idx;
    logic          active;
    logic          req_cur;

    // Scan downward so the lowest offset from ptr is the last match written.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        idx    = '0;
        for (int k = 15; k >= 0; k--) begin
            idx = ptr + 4'(k);
            if (bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign active  = (state != IDLE);
    assign req_cur = bus.req[sel_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            sel_q  <= '0;
            cnt    <= '0;
            dout_q <= 1'b0;
            dv_q   <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.en && found) begin
                        sel_q <= winner;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!req_cur) begin
                        ptr   <= sel_q + 4'd1;
                        state <= IDLE;
                    end else begin
                        cnt   <= CW'(HOLD_CYCLES - 1);
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!req_cur) begin
                        ptr   <= sel_q + 4'd1;
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        dout_q <= bus.mux_w;
                        dv_q   <= 1'b1;
                        ptr    <= sel_q + 4'd1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.grant = '0;
        if (active) bus.grant[sel_q] = 1'b1;
    end

    assign bus.sel        = sel_q;
    assign bus.sel_valid  = active;
    assign bus.busy       = active;
    assign bus.data_out   = dout_q;
    assign bus.data_valid = dv_q;
endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Self-checking bench for mux16_rr_scheduler: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level round-robin model.
module tb_mux16_rr_scheduler;
    localparam int HOLD = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux16_rr_scheduler_if bif();

    mux16_rr_scheduler #(.HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int vectors = 0;
    int miscompares = 0;

    // model: grant in progress, its source, cycles into the grant, next scan start
    bit m_busy;
    int m_sel;
    int m_age;
    int m_ptr;
    bit m_dout;
    bit m_dv;

    int starts[$];
    bit prev_sv;
    int dv_count;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_sel  = 0;
        m_age  = 0;
        m_ptr  = 0;
        m_dout = 0;
        m_dv   = 0;
        prev_sv = 0;
    endtask

    task automatic model_step();
        m_dv = 0;
        if (!m_busy) begin
            if (bif.en && bif.req != 16'h0) begin
                for (int i = 0; i < 16; i++) begin
                    int j;
                    j = (m_ptr + i) % 16;
                    if (bif.req[j]) begin
                        m_sel  = j;
                        m_busy = 1;
                        m_age  = 0;
                        break;
                    end
                end
            end
        end else if (!bif.req[m_sel]) begin
            m_busy = 0;
            m_ptr  = (m_sel + 1) % 16;
        end else if (m_age == HOLD) begin
            m_dout = bif.mux_w;
            m_dv   = 1;
            m_busy = 0;
            m_ptr  = (m_sel + 1) % 16;
        end else begin
            m_age++;
        end
    endtask

    task automatic compare_all();
        logic [31:0] g;
        g = m_busy ? (32'(1) << m_sel) : 32'h0;
        chk("sel", 32'(bif.sel), 32'(m_sel));
        chk("sel_valid", 32'(bif.sel_valid), 32'(m_busy));
        chk("grant", 32'(bif.grant), g);
        chk("data_out", 32'(bif.data_out), 32'(m_dout));
        chk("data_valid", 32'(bif.data_valid), 32'(m_dv));
        chk("busy", 32'(bif.busy), 32'(m_busy));
        if (bif.sel_valid && !prev_sv) starts.push_back(int'(bif.sel));
        prev_sv = bif.sel_valid;
        if (bif.data_valid) dv_count++;
    endtask

    // Called at a falling edge; drives inputs, advances model, checks after next edge.
    task automatic step(logic [15:0] r, logic e, logic w);
        bif.req   = r;
        bif.en    = e;
        bif.mux_w = w;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_sel_valid", 32'(bif.sel_valid), 32'h0);
        chk("rst_grant", 32'(bif.grant), 32'h0);
        chk("rst_data_valid", 32'(bif.data_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        starts.delete();
        dv_count = 0;
    endtask

    task automatic async_reset_mid();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] r;
        bif.req   = '0;
        bif.en    = 1'b0;
        bif.mux_w = 1'b0;
        model_reset();
        @(negedge clk);

        // single requester 5
        do_reset();
        step(16'h0020, 1, 1);
        chk("t1_sel", 32'(bif.sel), 32'd5);
        chk("t1_grant", 32'(bif.grant), 32'h20);
        step(16'h0020, 1, 1);
        step(16'h0020, 1, 1);
        chk("t1_grant_held", 32'(bif.grant), 32'h20);
        step(16'h0020, 1, 1);
        chk("t1_dv", 32'(bif.data_valid), 32'd1);
        chk("t1_dout", 32'(bif.data_out), 32'd1);
        chk("t1_grant_off", 32'(bif.grant), 32'h0);
        step(16'h0060, 1, 0);
        chk("t1_ptr6", 32'(bif.sel), 32'd6);
        repeat (3) step(16'h0060, 1, 0);
        chk("t1_dout0", 32'(bif.data_out), 32'd0);
        step(16'h0000, 1, 0);

        // full lap with every source requesting
        do_reset();
        for (int c = 0; c < 200 && dv_count < 16; c++)
            step(16'hFFFF, 1, 1'($urandom % 2));
        chk("t2_lap_dv", 32'(dv_count), 32'd16);
        chk("t2_lap_grants", 32'(starts.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            if (i < starts.size()) chk("t2_order", 32'(starts[i]), 32'(i));

        // wrap from 15 back to 0
        starts.delete();
        repeat (12) step(16'h8001, 1, 0);
        chk("t3_grants", 32'(starts.size()), 32'd3);
        if (starts.size() >= 3) begin
            chk("t3_first", 32'(starts[0]), 32'd0);
            chk("t3_second", 32'(starts[1]), 32'd15);
            chk("t3_third", 32'(starts[2]), 32'd0);
        end

        // abort in the second hold cycle
        do_reset();
        step(16'h0008, 1, 1);
        chk("t4_sel", 32'(bif.sel), 32'd3);
        step(16'h0008, 1, 1);
        step(16'h0008, 1, 1);
        step(16'h0000, 1, 1);
        chk("t4_abort_idle", 32'(bif.sel_valid), 32'd0);
        chk("t4_abort_nodv", 32'(bif.data_valid), 32'd0);
        step(16'h0018, 1, 0);
        chk("t4_next_ptr", 32'(bif.sel), 32'd4);
        repeat (3) step(16'h0018, 1, 0);
        step(16'h0000, 1, 0);

        // enable gating
        do_reset();
        repeat (3) begin
            step(16'h0100, 0, 1);
            chk("t5_blocked", 32'(bif.sel_valid), 32'd0);
        end
        step(16'h0100, 1, 1);
        chk("t5_sel", 32'(bif.sel), 32'd8);
        step(16'h0100, 0, 1);
        step(16'h0100, 0, 1);
        step(16'h0100, 0, 1);
        chk("t5_completes", 32'(bif.data_valid), 32'd1);

        // async reset mid-hold
        do_reset();
        step(16'h0400, 1, 1);
        step(16'h0400, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_sel", 32'(bif.sel), 32'd0);
        chk("t6_grant", 32'(bif.grant), 32'h0);
        chk("t6_sel_valid", 32'(bif.sel_valid), 32'd0);
        chk("t6_dv", 32'(bif.data_valid), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(16'h0001, 1, 0);
        chk("t6_first", 32'(bif.grant), 32'h1);

        // randomized traffic
        do_reset();
        r = 16'($urandom);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom % 8 == 0) r = 16'($urandom) & 16'($urandom);
            if ($urandom % 12 == 0) r = r ^ (16'(1) << ($urandom % 16));
            step(r, 1'(($urandom % 6) != 0), 1'($urandom % 2));
            if ($urandom % 400 == 0) async_reset_mid();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
